timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 96 +++++++++
 tb/tb_timer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// timer: start/halt controlled up-counter with live terminal-count compare,
// one-shot or auto-reload. Define TIMER_IRQ_EN to add the registered irq pulse.
module timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        rf_trig_start,
   input  logic        rf_trig_halt,
   input  logic        rf_mode,
   input  logic [31:0] rf_termcount,
   output logic        ro_status,
   output logic [31:0] ro_currcount
`ifdef TIMER_IRQ_EN
   ,
   output logic        irq
`endif
);

   // state  | meaning
   // S_IDLE | stopped (reset or halted), outputs held
   // S_RUN  | counting toward rf_termcount
   // S_DONE | one-shot finished, count and status held
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_count;
   logic [31:0] w_count_nxt;
   logic        r_status;
   logic        w_status_nxt;
   logic        r_start_q;
   logic        w_start_evt;
   logic        w_terminal;

   assign w_start_evt = rf_trig_start & ~r_start_q;
   // >= rather than == so a termcount lowered below the count still ends the run
   assign w_terminal  = (r_count >= rf_termcount);

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_status_nxt = r_status;
      if (rf_trig_halt) begin
         w_state_nxt = S_IDLE;
      end else if (w_start_evt) begin
         w_state_nxt  = S_RUN;
         w_count_nxt  = 32'd0;
         w_status_nxt = 1'b0;
      end else if (r_state == S_RUN) begin
         if (w_terminal) begin
            w_status_nxt = 1'b1;
            if (rf_mode) begin
               w_count_nxt = 32'd0;
            end else begin
               w_state_nxt = S_DONE;
            end
         end else begin
            w_count_nxt = r_count + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_count   <= 32'd0;
         r_status  <= 1'b0;
         r_start_q <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_status  <= w_status_nxt;
         r_start_q <= rf_trig_start;
      end
   end

   assign ro_currcount = r_count;
   assign ro_status    = r_status;

`ifdef TIMER_IRQ_EN
   logic w_term_evt;
   logic r_irq;

   assign w_term_evt = (r_state == S_RUN) & ~rf_trig_halt & ~w_start_evt & w_terminal;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_term_evt;
      end
   end

   assign irq = r_irq;
`endif

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus a randomized run,
// all checked against a rule-level reference model.
module tb_timer;
   logic        clk;
   logic        reset;
   logic        rf_trig_start;
   logic        rf_trig_halt;
   logic        rf_mode;
   logic [31:0] rf_termcount;
   logic        ro_status;
   logic [31:0] ro_currcount;
`ifdef TIMER_IRQ_EN
   logic        irq;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   timer dut (
      .clk          (clk),
      .reset        (reset),
      .rf_trig_start(rf_trig_start),
      .rf_trig_halt (rf_trig_halt),
      .rf_mode      (rf_mode),
      .rf_termcount (rf_termcount),
      .ro_status    (ro_status),
      .ro_currcount (ro_currcount)
`ifdef TIMER_IRQ_EN
      ,
      .irq          (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase of the timer plus its visible outputs.
   localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;
   int          m_phase  = P_IDLE;
   logic [31:0] m_count  = 32'd0;
   logic        m_status = 1'b0;
   logic        m_prev   = 1'b0;
   logic        m_irq    = 1'b0;

   function automatic void model_step();
      logic evt;
      m_irq = 1'b0;
      if (reset) begin
         m_phase = P_IDLE; m_count = 0; m_status = 0; m_prev = 0;
      end else begin
         evt    = rf_trig_start && !m_prev;
         m_prev = rf_trig_start;
         if (rf_trig_halt) begin
            m_phase = P_IDLE;
         end else if (evt) begin
            m_phase = P_RUN; m_count = 0; m_status = 0;
         end else if (m_phase == P_RUN) begin
            if (m_count >= rf_termcount) begin
               m_status = 1;
               m_irq    = 1;
               if (rf_mode) m_count = 0;
               else         m_phase = P_DONE;
            end else begin
               m_count = m_count + 1;
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1; rf_trig_start = 0; rf_trig_halt = 0; rf_mode = 0; rf_termcount = 5;
      tick(); tick();
      n_cmp++;
      if (ro_currcount !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", ro_currcount); end
      n_cmp++;
      if (ro_status !== 1'b0) begin n_bad++; $display("FAIL reset_status: got %0d expected 0", ro_status); end
`ifdef TIMER_IRQ_EN
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0d expected 0", irq); end
`endif
      reset = 0;
      tick();
   endtask

   task automatic test_one_shot();
      int ec[6] = '{0, 1, 2, 3, 3, 3};
      int es[6] = '{0, 0, 0, 0, 1, 1};
      int ei[6] = '{0, 0, 0, 0, 1, 0};
      rf_trig_start = 0; rf_termcount = 3; rf_mode = 0; tick();
      rf_trig_start = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++;
         if (ro_currcount !== 32'(ec[i])) begin n_bad++; $display("FAIL oneshot_count[%0d]: got %0d expected %0d", i, ro_currcount, ec[i]); end
         n_cmp++;
         if (ro_status !== 1'(es[i])) begin n_bad++; $display("FAIL oneshot_status[%0d]: got %0d expected %0d", i, ro_status, es[i]); end
`ifdef TIMER_IRQ_EN
         n_cmp++;
         if (irq !== 1'(ei[i])) begin n_bad++; $display("FAIL oneshot_irq[%0d]: got %0d expected %0d", i, irq, ei[i]); end
`endif
      end
   endtask

   task automatic test_continuous();
      int ec[7] = '{0, 1, 2, 0, 1, 2, 0};
      int es[7] = '{0, 0, 0, 1, 1, 1, 1};
      int ei[7] = '{0, 0, 0, 1, 0, 0, 1};
      rf_trig_start = 0; rf_termcount = 2; rf_mode = 1; tick();
      rf_trig_start = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_cmp++;
         if (ro_currcount !== 32'(ec[i])) begin n_bad++; $display("FAIL cont_count[%0d]: got %0d expected %0d", i, ro_currcount, ec[i]); end
         n_cmp++;
         if (ro_status !== 1'(es[i])) begin n_bad++; $display("FAIL cont_status[%0d]: got %0d expected %0d", i, ro_status, es[i]); end
`ifdef TIMER_IRQ_EN
         n_cmp++;
         if (irq !== 1'(ei[i])) begin n_bad++; $display("FAIL cont_irq[%0d]: got %0d expected %0d", i, irq, ei[i]); end
`endif
      end
   endtask

   task automatic test_halt();
      rf_trig_start = 0; rf_termcount = 10; rf_mode = 0; tick();
      rf_trig_start = 1; tick();
      repeat (5) tick();
      rf_trig_halt = 1; tick();
      n_cmp++;
      if (ro_currcount !== 32'd5) begin n_bad++; $display("FAIL halt_freeze: got %0d expected 5", ro_currcount); end
      rf_trig_halt = 0;
      repeat (3) tick();
      n_cmp++;
      if (ro_currcount !== 32'd5) begin n_bad++; $display("FAIL halt_release_no_edge: got %0d expected 5", ro_currcount); end
      rf_trig_start = 0; tick();
      rf_trig_start = 1; tick();
      n_cmp++;
      if (ro_currcount !== 32'd0) begin n_bad++; $display("FAIL halt_restart: got %0d expected 0", ro_currcount); end
      tick();
      n_cmp++;
      if (ro_currcount !== 32'd1) begin n_bad++; $display("FAIL halt_restart_run: got %0d expected 1", ro_currcount); end
   endtask

   task automatic test_start_with_halt();
      tick(); tick();
      rf_trig_start = 0; tick();
      rf_trig_start = 1; rf_trig_halt = 1; tick();
      n_cmp++;
      if (ro_currcount !== 32'd4) begin n_bad++; $display("FAIL starthalt_count: got %0d expected 4", ro_currcount); end
      rf_trig_halt = 0;
      repeat (3) tick();
      n_cmp++;
      if (ro_currcount !== 32'd4) begin n_bad++; $display("FAIL starthalt_no_restart: got %0d expected 4", ro_currcount); end
      n_cmp++;
      if (ro_status !== 1'b0) begin n_bad++; $display("FAIL starthalt_status: got %0d expected 0", ro_status); end
   endtask

   task automatic test_lower_termcount();
      rf_trig_start = 0; rf_termcount = 100; rf_mode = 0; tick();
      rf_trig_start = 1; tick();
      repeat (20) tick();
      n_cmp++;
      if (ro_currcount !== 32'd20) begin n_bad++; $display("FAIL lower_tc_pre: got %0d expected 20", ro_currcount); end
      rf_termcount = 4; tick();
      n_cmp++;
      if (ro_currcount !== 32'd20 || ro_status !== 1'b1) begin
         n_bad++; $display("FAIL lower_tc_done: got count %0d status %0d expected 20/1", ro_currcount, ro_status);
      end
      tick();
      n_cmp++;
      if (ro_currcount !== 32'd20) begin n_bad++; $display("FAIL lower_tc_hold: got %0d expected 20", ro_currcount); end
   endtask

   task automatic test_reset_midrun();
      rf_trig_start = 0; rf_termcount = 50; rf_mode = 0; tick();
      rf_trig_start = 1; tick();
      repeat (7) tick();
      n_cmp++;
      if (ro_currcount !== 32'd7) begin n_bad++; $display("FAIL midreset_pre: got %0d expected 7", ro_currcount); end
      reset = 1; tick();
      n_cmp++;
      if (ro_currcount !== 32'd0 || ro_status !== 1'b0) begin
         n_bad++; $display("FAIL midreset: got count %0d status %0d expected 0/0", ro_currcount, ro_status);
      end
`ifdef TIMER_IRQ_EN
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %0d expected 0", irq); end
`endif
      reset = 0; tick(); tick();
      n_cmp++;
      if (ro_currcount !== 32'd1) begin n_bad++; $display("FAIL post_reset_start: got %0d expected 1", ro_currcount); end
   endtask

   task automatic test_termcount_zero();
      rf_trig_start = 0; rf_termcount = 0; rf_mode = 0; tick();
      rf_trig_start = 1; tick(); tick();
      n_cmp++;
      if (ro_currcount !== 32'd0 || ro_status !== 1'b1) begin
         n_bad++; $display("FAIL tc0_oneshot: got count %0d status %0d expected 0/1", ro_currcount, ro_status);
      end
      rf_trig_start = 0; rf_mode = 1; tick();
      rf_trig_start = 1; tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (ro_currcount !== 32'd0 || ro_status !== 1'b1) begin
            n_bad++; $display("FAIL tc0_cont[%0d]: got count %0d status %0d expected 0/1", i, ro_currcount, ro_status);
         end
`ifdef TIMER_IRQ_EN
         n_cmp++;
         if (irq !== 1'b1) begin n_bad++; $display("FAIL tc0_cont_irq[%0d]: got %0d expected 1", i, irq); end
`endif
      end
   endtask

   task automatic test_random();
      int errs_here;
      errs_here = 0;
      rf_trig_halt = 0;
      for (int i = 0; i < 4000; i++) begin
         reset         = ($urandom_range(149) == 0);
         rf_trig_halt  = ($urandom_range(24) == 0);
         if ($urandom_range(6) == 0)  rf_trig_start = ~rf_trig_start;
         if ($urandom_range(40) == 0) rf_mode = ~rf_mode;
         if ($urandom_range(30) == 0) rf_termcount = 32'($urandom_range(12));
         tick();
         n_cmp++;
         if (ro_currcount !== m_count || ro_status !== m_status) begin
            n_bad++;
            if (errs_here < 10)
               $display("FAIL rand[%0d]: got count %0d status %0d expected %0d/%0d", i, ro_currcount, ro_status, m_count, m_status);
            errs_here++;
         end
`ifdef TIMER_IRQ_EN
         n_cmp++;
         if (irq !== m_irq) begin
            n_bad++;
            if (errs_here < 10) $display("FAIL rand_irq[%0d]: got %0d expected %0d", i, irq, m_irq);
            errs_here++;
         end
`endif
      end
      reset = 0;
   endtask

   initial begin
      reset = 1; rf_trig_start = 0; rf_trig_halt = 0; rf_mode = 0; rf_termcount = 0;
      test_reset();
      test_one_shot();
      test_continuous();
      test_halt();
      test_start_with_halt();
      test_lower_termcount();
      test_reset_midrun();
      test_termcount_zero();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
